// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, ALU op encoding and the ID/EX record.
// BUBBLE (addi x0,x0,0) is the idle value for both the decoder and the ID/EX register.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RAW  = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [4:0] {
    ALU_ADD = 5'b00001,
    ALU_SUB = 5'b00010,
    ALU_XOR = 5'b00100,
    ALU_OR  = 5'b01000,
    ALU_AND = 5'b10000
  } alu_op_e;

  typedef struct packed {
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic            wb_en;
    logic            alu_rs2_reg;
    alu_op_e         alu_op;
    logic            rs1_loopback;
    logic            rs2_loopback;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '{
    rd:           '0,
    rs1_val:      '0,
    rs2_val:      '0,
    imm:          '0,
    wb_en:        1'b1,
    alu_rs2_reg:  1'b0,
    alu_op:       ALU_ADD,
    rs1_loopback: 1'b0,
    rs2_loopback: 1'b0
  };

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{(XLEN-12){instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: 2 async read ports, 1 sync write port, x0 fixed at zero.
// A read hitting the register being written this cycle sees the new data.
module reg_file
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RAW-1:0]  rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [RAW-1:0]  rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] word [NREG];
  logic            wr_hit_rs1;
  logic            wr_hit_rs2;

  // Each register lives in its own generate block so x0 never gets storage.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign word[gi] = '0;
    end else begin : g_store
      logic [XLEN-1:0] q_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (wb_en && wb_addr == RAW'(gi)) begin
          q_reg <= wb_data;
        end
      end
      assign word[gi] = q_reg;
    end
  end

  assign wr_hit_rs1 = wb_en && (wb_addr == rs1_addr);
  assign wr_hit_rs2 = wb_en && (wb_addr == rs2_addr);

  always_comb begin
    rs1_data = word[rs1_addr];
    rs2_data = word[rs2_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (wr_hit_rs1) begin
      rs1_data = wb_data;
    end
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (wr_hit_rs2) begin
      rs2_data = wb_data;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: ALU-op decoder, operand read, immediate generation,
// EX->ID loopback hazard flags and sticky illegal-instruction tracking.
module id_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid_in,
  input  logic [31:0]     instr_in,
  input  logic            flush_in,
  input  logic            wb_en_in,
  input  logic [RAW-1:0]  wb_addr_in,
  input  logic [XLEN-1:0] wb_data_in,
  output logic [RAW-1:0]  rd_addr_out,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  output logic            writeback_en_out,
  output logic            alu_rs2_reg_out,
  output logic [XLEN-1:0] imm_out,
  output logic            add_en_out,
  output logic            sub_en_out,
  output logic            xor_en_out,
  output logic            or_en_out,
  output logic            and_en_out,
  output logic            rs1_alu_loopback_out,
  output logic            rs2_alu_loopback_out,
  output logic            illegal_out,
  output logic            illegal_seen_out
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RAW-1:0]  rd_addr;
  logic [RAW-1:0]  rs1_addr;
  logic [RAW-1:0]  rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            is_r;
  logic            legal;
  logic            live;
  logic            issue;
  alu_op_e         alu_op;
  id_ex_t          id_ex;

  logic [RAW-1:0]  prev_rd_reg, prev_rd_next;
  logic            prev_wb_reg, prev_wb_next;
  logic            illegal_seen_reg, illegal_seen_next;

  assign opcode   = instr_in[6:0];
  assign rd_addr  = instr_in[11:7];
  assign funct3   = instr_in[14:12];
  assign rs1_addr = instr_in[19:15];
  assign rs2_addr = instr_in[24:20];
  assign funct7   = instr_in[31:25];
  assign is_r     = (opcode == OPC_OP);

  reg_file u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs1_data (rs1_data),
    .rs2_addr (rs2_addr),
    .rs2_data (rs2_data),
    .wb_en    (wb_en_in),
    .wb_addr  (wb_addr_in),
    .wb_data  (wb_data_in)
  );

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    if (opcode == OPC_OP) begin
      case (funct3)
        F3_ADD: begin
          if (funct7 == F7_BASE) begin
            legal = 1'b1;
            alu_op = ALU_ADD;
          end else if (funct7 == F7_SUB) begin
            legal = 1'b1;
            alu_op = ALU_SUB;
          end
        end
        F3_XOR: if (funct7 == F7_BASE) begin legal = 1'b1; alu_op = ALU_XOR; end
        F3_OR:  if (funct7 == F7_BASE) begin legal = 1'b1; alu_op = ALU_OR;  end
        F3_AND: if (funct7 == F7_BASE) begin legal = 1'b1; alu_op = ALU_AND; end
        default: ;
      endcase
    end else if (opcode == OPC_OP_IMM) begin
      case (funct3)
        F3_ADD: begin legal = 1'b1; alu_op = ALU_ADD; end
        F3_XOR: begin legal = 1'b1; alu_op = ALU_XOR; end
        F3_OR:  begin legal = 1'b1; alu_op = ALU_OR;  end
        F3_AND: begin legal = 1'b1; alu_op = ALU_AND; end
        default: ;
      endcase
    end
  end

  // Reset is folded in so the outputs show a bubble the moment rst_n drops.
  assign live        = rst_n && instr_valid_in && !flush_in;
  assign issue       = live && legal;
  assign illegal_out = live && !legal;

  always_comb begin
    id_ex = BUBBLE;
    if (issue) begin
      id_ex.rd           = rd_addr;
      id_ex.rs1_val      = rs1_data;
      id_ex.rs2_val      = is_r ? rs2_data : '0;
      id_ex.imm          = is_r ? '0 : imm_i(instr_in);
      id_ex.alu_rs2_reg  = is_r;
      id_ex.alu_op       = alu_op;
      id_ex.rs1_loopback = prev_wb_reg && (prev_rd_reg != '0) && (rs1_addr == prev_rd_reg);
      id_ex.rs2_loopback = is_r && prev_wb_reg && (prev_rd_reg != '0) &&
                           (rs2_addr == prev_rd_reg);
    end
  end

  assign prev_rd_next      = flush_in ? '0   : id_ex.rd;
  assign prev_wb_next      = flush_in ? 1'b0 : id_ex.wb_en;
  assign illegal_seen_next = illegal_seen_reg || illegal_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_rd_reg      <= '0;
      prev_wb_reg      <= 1'b0;
      illegal_seen_reg <= 1'b0;
    end else begin
      prev_rd_reg      <= prev_rd_next;
      prev_wb_reg      <= prev_wb_next;
      illegal_seen_reg <= illegal_seen_next;
    end
  end

  assign rd_addr_out          = id_ex.rd;
  assign rs1_out              = id_ex.rs1_val;
  assign rs2_out              = id_ex.rs2_val;
  assign imm_out              = id_ex.imm;
  assign writeback_en_out     = id_ex.wb_en;
  assign alu_rs2_reg_out      = id_ex.alu_rs2_reg;
  assign add_en_out           = id_ex.alu_op[0];
  assign sub_en_out           = id_ex.alu_op[1];
  assign xor_en_out           = id_ex.alu_op[2];
  assign or_en_out            = id_ex.alu_op[3];
  assign and_en_out           = id_ex.alu_op[4];
  assign rs1_alu_loopback_out = id_ex.rs1_loopback;
  assign rs2_alu_loopback_out = id_ex.rs2_loopback;
  assign illegal_seen_out     = illegal_seen_reg;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected decode records are queued as stimulus
// is driven and compared against the outputs on the following falling edge.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid_in;
  logic [31:0] instr_in;
  logic        flush_in;
  logic        wb_en_in;
  logic [4:0]  wb_addr_in;
  logic [31:0] wb_data_in;
  logic [4:0]  rd_addr_out;
  logic [31:0] rs1_out, rs2_out, imm_out;
  logic        writeback_en_out, alu_rs2_reg_out;
  logic        add_en_out, sub_en_out, xor_en_out, or_en_out, and_en_out;
  logic        rs1_alu_loopback_out, rs2_alu_loopback_out;
  logic        illegal_out, illegal_seen_out;

  always #5 clk = ~clk;

  id_stage dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .instr_valid_in       (instr_valid_in),
    .instr_in             (instr_in),
    .flush_in             (flush_in),
    .wb_en_in             (wb_en_in),
    .wb_addr_in           (wb_addr_in),
    .wb_data_in           (wb_data_in),
    .rd_addr_out          (rd_addr_out),
    .rs1_out              (rs1_out),
    .rs2_out              (rs2_out),
    .writeback_en_out     (writeback_en_out),
    .alu_rs2_reg_out      (alu_rs2_reg_out),
    .imm_out              (imm_out),
    .add_en_out           (add_en_out),
    .sub_en_out           (sub_en_out),
    .xor_en_out           (xor_en_out),
    .or_en_out            (or_en_out),
    .and_en_out           (and_en_out),
    .rs1_alu_loopback_out (rs1_alu_loopback_out),
    .rs2_alu_loopback_out (rs2_alu_loopback_out),
    .illegal_out          (illegal_out),
    .illegal_seen_out     (illegal_seen_out)
  );

  // op field order: {and, or, xor, sub, add}
  localparam logic [4:0] OP_ADD = 5'b00001, OP_SUB = 5'b00010, OP_XOR = 5'b00100,
                         OP_OR  = 5'b01000, OP_AND = 5'b10000;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        rs2reg;
    logic [4:0]  op;
    logic        lb1;
    logic        lb2;
    logic        ill;
    logic        seen;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, expv);
  endtask

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic rs2reg, input logic [4:0] op, input logic lb1,
                              input logic lb2, input logic ill, input logic seen);
    exp_t e;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rs2reg = rs2reg; e.op = op;
    e.lb1 = lb1; e.lb2 = lb2; e.ill = ill; e.seen = seen;
    return e;
  endfunction

  function automatic exp_t bubble(input logic ill, input logic seen);
    return mk(5'd0, 32'd0, 32'd0, 32'd0, 1'b0, OP_ADD, 1'b0, 1'b0, ill, seen);
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input exp_t e);
    instr_valid_in = v;
    instr_in       = ins;
    flush_in       = fl;
    wb_en_in       = we;
    wb_addr_in     = wa;
    wb_data_in     = wd;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    n_txn++;
    $display("txn %0d instr=%08h v=%0b fl=%0b rd=%0d rs1=%08h rs2=%08h imm=%08h op=%05b lb=%0b%0b ill=%0b seen=%0b",
             n_txn, instr_in, instr_valid_in, flush_in, rd_addr_out, rs1_out, rs2_out,
             imm_out, {and_en_out, or_en_out, xor_en_out, sub_en_out, add_en_out},
             rs1_alu_loopback_out, rs2_alu_loopback_out, illegal_out, illegal_seen_out);
    check("rd",      32'(rd_addr_out), 32'(e.rd));
    check("rs1",     rs1_out, e.rs1);
    check("rs2",     rs2_out, e.rs2);
    check("imm",     imm_out, e.imm);
    check("wb_en",   32'(writeback_en_out), 32'd1);
    check("rs2reg",  32'(alu_rs2_reg_out), 32'(e.rs2reg));
    check("alu_op",  32'({and_en_out, or_en_out, xor_en_out, sub_en_out, add_en_out}),
          32'(e.op));
    check("lb1",     32'(rs1_alu_loopback_out), 32'(e.lb1));
    check("lb2",     32'(rs2_alu_loopback_out), 32'(e.lb2));
    check("illegal", 32'(illegal_out), 32'(e.ill));
    check("seen",    32'(illegal_seen_out), 32'(e.seen));
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input exp_t e);
    drive(v, ins, fl, we, wa, wd, e);
    sample();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] F7Z = 7'b0000000, F7S = 7'b0100000;

  initial begin
    // Reset held with a live add on the bus
    rst_n = 1'b0;
    drive(1'b1, r_op(F7Z, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0,
          bubble(1'b0, 1'b0));
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // WB x5, then addi x6,x5,1 reads it from the file
    step(1'b0, 32'd0, 1'b0, 1'b1, 5'd5, 32'h1234, bubble(1'b0, 1'b0));
    step(1'b1, i_op(12'd1, 5'd5, 3'b000, 5'd6), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd6, 32'h1234, 32'd0, 32'd1, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0));
    // Same-cycle WB x7 with xor x8,x7,x7: write-through
    step(1'b1, r_op(F7Z, 5'd7, 5'd7, 3'b100, 5'd8), 1'b0, 1'b1, 5'd7, 32'hDEAD,
         mk(5'd8, 32'hDEAD, 32'hDEAD, 32'd0, 1'b1, OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0));

    // Loopback hazards
    step(1'b1, r_op(F7Z, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd3, 32'd0, 32'd0, 32'd0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, r_op(F7S, 5'd3, 5'd3, 3'b000, 5'd4), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd4, 32'd0, 32'd0, 32'd0, 1'b1, OP_SUB, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b1, i_op(12'd3, 5'd4, 3'b000, 5'd9), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd9, 32'd0, 32'd0, 32'd3, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b1, r_op(F7Z, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd3, 32'd0, 32'd0, 32'd0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b0, r_op(F7Z, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0,
         bubble(1'b0, 1'b0));
    step(1'b1, r_op(F7S, 5'd3, 5'd3, 3'b000, 5'd4), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd4, 32'd0, 32'd0, 32'd0, 1'b1, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, r_op(F7Z, 5'd2, 5'd1, 3'b000, 5'd0), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd0, 32'd0, 32'd0, 32'd0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, r_op(F7S, 5'd0, 5'd0, 3'b000, 5'd4), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd4, 32'd0, 32'd0, 32'd0, 1'b1, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0));
    // Flush squashes and clears the tracked producer
    step(1'b1, r_op(F7Z, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd3, 32'd0, 32'd0, 32'd0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, r_op(F7S, 5'd3, 5'd3, 3'b000, 5'd4), 1'b1, 1'b0, 5'd0, 32'd0,
         bubble(1'b0, 1'b0));
    step(1'b1, r_op(F7S, 5'd3, 5'd3, 3'b000, 5'd4), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd4, 32'd0, 32'd0, 32'd0, 1'b1, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0));

    // x0 is never written; immediates sign-extend
    step(1'b1, r_op(F7Z, 5'd0, 5'd0, 3'b110, 5'd1), 1'b0, 1'b1, 5'd0, 32'hFFFF,
         mk(5'd1, 32'd0, 32'd0, 32'd0, 1'b1, OP_OR, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, i_op(12'hFFF, 5'd0, 3'b000, 5'd1), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, i_op(12'h0F0, 5'd5, 3'b110, 5'd10), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd10, 32'h1234, 32'd0, 32'h000000F0, 1'b0, OP_OR, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, i_op(12'h800, 5'd7, 3'b111, 5'd11), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd11, 32'hDEAD, 32'd0, 32'hFFFFF800, 1'b0, OP_AND, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, i_op(12'h555, 5'd5, 3'b100, 5'd12), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd12, 32'h1234, 32'd0, 32'h00000555, 1'b0, OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0));

    // Illegal handling
    step(1'b0, 32'h00000073, 1'b0, 1'b0, 5'd0, 32'd0, bubble(1'b0, 1'b0));
    step(1'b1, 32'h00000073, 1'b0, 1'b0, 5'd0, 32'd0, bubble(1'b1, 1'b0));
    step(1'b1, r_op(F7Z, 5'd7, 5'd5, 3'b000, 5'd12), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd12, 32'h1234, 32'hDEAD, 32'd0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1));
    step(1'b1, 32'h00000073, 1'b1, 1'b0, 5'd0, 32'd0, bubble(1'b0, 1'b1));
    step(1'b1, r_op(F7S, 5'd2, 5'd1, 3'b111, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0,
         bubble(1'b1, 1'b1));

    // Asynchronous reset mid-cycle clears everything, including the file
    drive(1'b1, r_op(F7Z, 5'd7, 5'd5, 3'b000, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0,
          bubble(1'b0, 1'b0));
    #2;
    rst_n = 1'b0;
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, r_op(F7Z, 5'd7, 5'd5, 3'b000, 5'd13), 1'b0, 1'b0, 5'd0, 32'd0,
         mk(5'd13, 32'd0, 32'd0, 32'd0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0));

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
